// File: rtl/mc_pkg.sv
// mc_pkg: state, ALU-control, select and error encodings shared by the controller and its decoder
package mc_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADDU = 4'b0000,
      ALU_SUBU = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_NOR  = 4'b0111,
      ALU_LUI  = 4'b1000,
      ALU_SLTU = 4'b1010,
      ALU_SLT  = 4'b1011,
      ALU_SRA  = 4'b1100,
      ALU_SRL  = 4'b1101,
      ALU_SLL  = 4'b1110
   } aluc_t;

   typedef enum logic [3:0] {
      C_ALU, C_ALUI, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_LW, C_SW
   } cls_t;

   localparam logic [1:0] PC_4 = 2'd0, PC_BR = 2'd1, PC_J = 2'd2, PC_RS = 2'd3;
   localparam logic [1:0] WB_ALU = 2'd0, WB_DM = 2'd1, WB_PC4 = 2'd2;
   localparam logic [1:0] RD_RD = 2'd0, RD_RT = 2'd1, RD_31 = 2'd2;
   localparam logic       A_RS = 1'b0, A_SHAMT = 1'b1;
   localparam logic [1:0] B_RT = 2'd0, B_SEXT = 2'd1, B_ZEXT = 2'd2;
   localparam logic [1:0] ERR_NONE = 2'd0, ERR_ILL = 2'd1, ERR_TMO = 2'd2;

   typedef struct packed {
      cls_t       cls;
      aluc_t      aluc;
      logic       a_sel;
      logic [1:0] b_sel;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational op/func decode into instruction class, ALU control, operand selects and illegal flag
module mc_decode
   import mc_pkg::*;
#(
   parameter bit EN_SHIFTV = 1'b1
) (
   input  logic [5:0] op,
   input  logic [5:0] func,
   output dec_t       dec
);

   always_comb begin
      dec = '{C_ALU, ALU_ADDU, A_RS, B_RT, 1'b0};
      case (op)
         6'h00:
            case (func)
               6'h00: begin dec.aluc = ALU_SLL; dec.a_sel = A_SHAMT; end
               6'h02: begin dec.aluc = ALU_SRL; dec.a_sel = A_SHAMT; end
               6'h03: begin dec.aluc = ALU_SRA; dec.a_sel = A_SHAMT; end
               6'h04: begin dec.aluc = ALU_SLL; dec.illegal = !EN_SHIFTV; end
               6'h06: begin dec.aluc = ALU_SRL; dec.illegal = !EN_SHIFTV; end
               6'h07: begin dec.aluc = ALU_SRA; dec.illegal = !EN_SHIFTV; end
               6'h08: dec.cls = C_JR;
               6'h20: dec.aluc = ALU_ADD;
               6'h21: dec.aluc = ALU_ADDU;
               6'h22: dec.aluc = ALU_SUB;
               6'h23: dec.aluc = ALU_SUBU;
               6'h24: dec.aluc = ALU_AND;
               6'h25: dec.aluc = ALU_OR;
               6'h26: dec.aluc = ALU_XOR;
               6'h27: dec.aluc = ALU_NOR;
               6'h2A: dec.aluc = ALU_SLT;
               6'h2B: dec.aluc = ALU_SLTU;
               default: dec.illegal = 1'b1;
            endcase
         6'h02: dec = '{C_J,    ALU_ADDU, A_RS, B_RT,   1'b0};
         6'h03: dec = '{C_JAL,  ALU_ADDU, A_RS, B_RT,   1'b0};
         6'h04: dec = '{C_BEQ,  ALU_SUBU, A_RS, B_RT,   1'b0};
         6'h05: dec = '{C_BNE,  ALU_SUBU, A_RS, B_RT,   1'b0};
         6'h08: dec = '{C_ALUI, ALU_ADD,  A_RS, B_SEXT, 1'b0};
         6'h09: dec = '{C_ALUI, ALU_ADDU, A_RS, B_SEXT, 1'b0};
         6'h0A: dec = '{C_ALUI, ALU_SLT,  A_RS, B_SEXT, 1'b0};
         6'h0B: dec = '{C_ALUI, ALU_SLTU, A_RS, B_SEXT, 1'b0};
         6'h0C: dec = '{C_ALUI, ALU_AND,  A_RS, B_ZEXT, 1'b0};
         6'h0D: dec = '{C_ALUI, ALU_OR,   A_RS, B_ZEXT, 1'b0};
         6'h0E: dec = '{C_ALUI, ALU_XOR,  A_RS, B_ZEXT, 1'b0};
         6'h0F: dec = '{C_ALUI, ALU_LUI,  A_RS, B_ZEXT, 1'b0};
         6'h23: dec = '{C_LW,   ALU_ADDU, A_RS, B_SEXT, 1'b0};
         6'h2B: dec = '{C_SW,   ALU_ADDU, A_RS, B_SEXT, 1'b0};
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS-subset control FSM with memory-wait timeout, halt state and retired counter
module mc_controller
   import mc_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int TMO       = 15,
   parameter bit EN_SHIFTV = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             Z,
   input  logic             mem_ready,
   output logic             im_r,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_w,
   output logic             dm_r,
   output logic             dm_w,
   output logic [3:0]       aluc,
   output logic [1:0]       pc_sel,
   output logic [1:0]       wb_sel,
   output logic [1:0]       rd_sel,
   output logic             alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic [2:0]       state,
   output logic             instr_done,
   output logic             halted,
   output logic [1:0]       err,
   output logic [CNT_W-1:0] retired
);

   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   dec_t             dec;
   state_t           state_q, state_d;
   logic [1:0]       err_q, err_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             taken, timeout;

   mc_decode #(.EN_SHIFTV(EN_SHIFTV)) u_decode (.op(op), .func(func), .dec(dec));

   assign taken   = (dec.cls == C_BEQ) ? Z : !Z;
   assign timeout = !mem_ready && wait_q == TMO_LAST;
   assign state   = state_q;
   assign err     = err_q;
   assign retired = retired_q;

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      wait_d     = '0;
      im_r       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_w       = 1'b0;
      dm_r       = 1'b0;
      dm_w       = 1'b0;
      aluc       = 4'b0000;
      pc_sel     = PC_4;
      wb_sel     = WB_ALU;
      rd_sel     = RD_RD;
      alu_a_sel  = A_RS;
      alu_b_sel  = B_RT;
      instr_done = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_IF: begin
            im_r = 1'b1;
            // strobes stay quiet while reset is held so only im_r shows
            if (mem_ready && rst_n) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_ID;
            end else if (!mem_ready) begin
               wait_d  = wait_q + 8'd1;
               state_d = timeout ? S_HALT : S_IF;
               err_d   = timeout ? ERR_TMO : err_q;
            end
         end
         S_ID:
            if (dec.illegal) begin
               state_d = S_HALT;
               err_d   = ERR_ILL;
            end else begin
               pc_we      = dec.cls == C_J || dec.cls == C_JR || dec.cls == C_JAL;
               pc_sel     = (dec.cls == C_JR) ? PC_RS : pc_we ? PC_J : PC_4;
               instr_done = dec.cls == C_J || dec.cls == C_JR;
               state_d    = instr_done ? S_IF : (dec.cls == C_JAL) ? S_WB : S_EX;
            end
         S_EX: begin
            aluc      = dec.aluc;
            alu_a_sel = dec.a_sel;
            alu_b_sel = dec.b_sel;
            if (dec.cls == C_BEQ || dec.cls == C_BNE) begin
               pc_we      = taken;
               pc_sel     = taken ? PC_BR : PC_4;
               instr_done = 1'b1;
               state_d    = S_IF;
            end else begin
               state_d = (dec.cls == C_LW || dec.cls == C_SW) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            dm_r = dec.cls == C_LW;
            dm_w = dec.cls == C_SW;
            if (mem_ready) begin
               instr_done = dm_w;
               state_d    = dm_r ? S_WB : S_IF;
            end else begin
               wait_d  = wait_q + 8'd1;
               state_d = timeout ? S_HALT : S_MEM;
               err_d   = timeout ? ERR_TMO : err_q;
            end
         end
         S_WB: begin
            rf_w       = 1'b1;
            wb_sel     = (dec.cls == C_JAL) ? WB_PC4 : (dec.cls == C_LW) ? WB_DM : WB_ALU;
            rd_sel     = (dec.cls == C_JAL) ? RD_31 : (dec.cls == C_LW || dec.cls == C_ALUI) ? RD_RT : RD_RD;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IF;
      endcase
      retired_d = retired_q + CNT_W'(instr_done);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IF;
         err_q     <= ERR_NONE;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

endmodule
